mem_wb_stage: RTL and testbench

Final pipeline stage of the five-stage CPU: latches one retiring instruction from the MEM stage, extracts and extends load data, selects the writeback source, and drives the write port (`wa`/`we`/`wd`) of `register_file`. It also holds for the debug halt, squashes on flush, counts retired instructions and, optionally, exports a forwarding path to the ID/EX bypass logic.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/load_extend.sv | 44 ++++
 rtl/mem_wb_stage.sv | 119 +++++++++++
 tb/tb_mem_wb_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback-source select codes, load-type encodings
// (also consumed by the decoder) and the MEM/WB stage register layout.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  // One retiring instruction as held by the MEM/WB stage register.
  typedef struct packed {
    logic [4:0]      rd;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic [2:0]      ld_type;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] pc4;
  } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: selects the addressed byte/half of a 32-bit memory
// word and sign- or zero-extends it according to the load type.
// Ports:
//   ld_type  in  3   load encoding (LB/LH/LW/LBU/LHU; unknown codes -> LW)
//   addr_lo  in  2   low address bits
//   mem_data in  32  raw memory word
//   ld_data  out 32  extended load result
module load_extend
  import cpu_pkg::*;
(
  input  logic [2:0]      ld_type,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_data[7:0];
    case (addr_lo)
      2'd1:    byte_sel = mem_data[15:8];
      2'd2:    byte_sel = mem_data[23:16];
      2'd3:    byte_sel = mem_data[31:24];
      default: byte_sel = mem_data[7:0];
    endcase
  end

  // Halfword picks on addr_lo[1] only; a misaligned addr_lo[0] is ignored.
  assign half_sel = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];

  always_comb begin
    ld_data = mem_data;
    case (ld_type)
      LD_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      LD_LBU:  ld_data = {24'd0, byte_sel};
      LD_LHU:  ld_data = {16'd0, half_sel};
      default: ld_data = mem_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: latches one retiring instruction, extracts load
// data, selects the writeback source and drives the register_file write port.
// Supports a debug hold (freeze), flush (squash) and a retired-instruction
// counter. Optional bypass export is enabled by defining WB_FWD_EN.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid / in_ready           handshake with MEM (in_ready = !wb_hold)
//   in_rd, in_reg_write, in_wb_sel, in_ld_type, in_addr_lo,
//   in_alu_res, in_mem_data, in_pc4   instruction fields from MEM
//   flush, wb_hold                squash / debug freeze
//   rf_wa, rf_we, rf_wd           register_file write port
//   instret                       retired-instruction count (wraps)
//   fwd_valid, fwd_rd, fwd_data   bypass export (WB_FWD_EN only)
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32  // must be 32: load extraction assumes 4-byte words
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_ld_type,
  input  logic [1:0]       in_addr_lo,
  input  logic [WIDTH-1:0] in_alu_res,
  input  logic [WIDTH-1:0] in_mem_data,
  input  logic [WIDTH-1:0] in_pc4,
  input  logic             flush,
  input  logic             wb_hold,
  output logic [4:0]       rf_wa,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_wd,
`ifdef WB_FWD_EN
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [WIDTH-1:0] fwd_data,
`endif
  output logic [31:0]      instret
);

  wb_entry_t   ent_q, ent_d;
  logic        valid_q, valid_d;
  logic [31:0] instret_q, instret_d;
  logic        capture, retire;
  logic [WIDTH-1:0] ld_data;

  assign in_ready = !wb_hold;
  assign capture  = in_valid && in_ready && !flush;
  // An entry leaves exactly once: on the first unheld, unflushed edge.
  assign retire   = valid_q && !wb_hold && !flush;

  always_comb begin
    ent_d = ent_q;
    if (capture) begin
      ent_d.rd        = in_rd;
      ent_d.reg_write = in_reg_write;
      ent_d.wb_sel    = in_wb_sel;
      ent_d.ld_type   = in_ld_type;
      ent_d.addr_lo   = in_addr_lo;
      ent_d.alu_res   = in_alu_res;
      ent_d.mem_data  = in_mem_data;
      ent_d.pc4       = in_pc4;
    end
  end

  // flush beats capture, capture beats drain, hold keeps the entry.
  always_comb begin
    valid_d = 1'b0;
    if (flush)        valid_d = 1'b0;
    else if (capture) valid_d = 1'b1;
    else if (wb_hold) valid_d = valid_q;
  end

  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q     <= '0;
      valid_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      ent_q     <= ent_d;
      valid_q   <= valid_d;
      instret_q <= instret_d;
    end
  end

  load_extend u_load_extend (
    .ld_type  (ent_q.ld_type),
    .addr_lo  (ent_q.addr_lo),
    .mem_data (ent_q.mem_data),
    .ld_data  (ld_data)
  );

  // Reserved select 3 falls back to the ALU result.
  always_comb begin
    rf_wd = ent_q.alu_res;
    case (ent_q.wb_sel)
      WB_SEL_LOAD: rf_wd = ld_data;
      WB_SEL_PC4:  rf_wd = ent_q.pc4;
      default:     rf_wd = ent_q.alu_res;
    endcase
  end

  assign rf_wa   = ent_q.rd;
  assign rf_we   = retire && ent_q.reg_write && (ent_q.rd != 5'd0);
  assign instret = instret_q;

`ifdef WB_FWD_EN
  // Bypass stays live through a hold so ID/EX can keep forwarding.
  assign fwd_valid = valid_q && ent_q.reg_write && (ent_q.rd != 5'd0);
  assign fwd_rd    = ent_q.rd;
  assign fwd_data  = rf_wd;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  import cpu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_rd = '0;
  logic             in_reg_write = 1'b0;
  logic [1:0]       in_wb_sel = '0;
  logic [2:0]       in_ld_type = '0;
  logic [1:0]       in_addr_lo = '0;
  logic [WIDTH-1:0] in_alu_res = '0;
  logic [WIDTH-1:0] in_mem_data = '0;
  logic [WIDTH-1:0] in_pc4 = '0;
  logic             flush = 1'b0;
  logic             wb_hold = 1'b0;
  logic [4:0]       rf_wa;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wd;
  logic [31:0]      instret;
`ifdef WB_FWD_EN
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [WIDTH-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected register-file writes, in issue order.
  logic [4:0]  q_rd[$];
  logic [31:0] q_wd[$];
  logic [31:0] rf_model[32];
  logic [31:0] exp_instret = '0;

  // Load extraction vectors
  logic [2:0]  lt[8] = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW, 3'd3, LD_LB, LD_LH};
  logic [1:0]  al[8] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3};
  logic [31:0] md[8] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80011234, 32'h80011234,
                         32'h80011234, 32'h80011234, 32'h80FF7F01, 32'h80011234};
  logic [31:0] ex[8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00001234,
                         32'h80011234, 32'h80011234, 32'h00000001, 32'hFFFF8001};

  mem_wb_stage #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_wb_sel    (in_wb_sel),
    .in_ld_type   (in_ld_type),
    .in_addr_lo   (in_addr_lo),
    .in_alu_res   (in_alu_res),
    .in_mem_data  (in_mem_data),
    .in_pc4       (in_pc4),
    .flush        (flush),
    .wb_hold      (wb_hold),
    .rf_wa        (rf_wa),
    .rf_we        (rf_we),
    .rf_wd        (rf_wd),
`ifdef WB_FWD_EN
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
`endif
    .instret      (instret)
  );

  always #5 clk = ~clk;

  // Write monitor: inputs change just after posedge, so at negedge rf_we is
  // stable and names the write committed at the following posedge.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (q_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write wa=%0d wd=%h", rf_wa, rf_wd);
      end else begin
        logic [4:0]  er;
        logic [31:0] ed;
        er = q_rd.pop_front();
        ed = q_wd.pop_front();
        if (rf_wa !== er || rf_wd !== ed) begin
          errors++;
          $display("FAIL write_data got wa=%0d wd=%h want wa=%0d wd=%h", rf_wa, rf_wd, er, ed);
        end
      end
      rf_model[rf_wa] = rf_wd;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rd, input logic rw,
                        input logic [1:0] sel, input logic [2:0] ld, input logic [1:0] alo,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
    in_valid = v; in_rd = rd; in_reg_write = rw; in_wb_sel = sel; in_ld_type = ld;
    in_addr_lo = alo; in_alu_res = alu; in_mem_data = mem; in_pc4 = pc4;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    q_rd.push_back(rd);
    q_wd.push_back(d);
  endtask

  task automatic do_reset;
    in_valid = 1'b0; flush = 1'b0; wb_hold = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_reset;
    tick; tick;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    checks++; if (rf_wa !== 5'd0) begin errors++; $display("FAIL reset_rf_wa got %0d want 0", rf_wa); end
    checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_wd got %h want 0", rf_wd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
    wb_hold = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b want 0", in_ready); end
    wb_hold = 1'b0;
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_loads;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 5'd5, 1'b1, WB_SEL_LOAD, lt[i], al[i], 32'h11111111, md[i], 32'h22222222);
      expect_wr(5'd5, ex[i]);
      exp_instret++;
      tick;
      in_valid = 1'b0; #1;
      checks++;
      if (rf_we !== 1'b1 || rf_wd !== ex[i]) begin
        errors++;
        $display("FAIL load_%0d got we=%b wd=%h want we=1 wd=%h", i, rf_we, rf_wd, ex[i]);
      end
      tick;
    end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL load_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_wb_sel;
    logic [1:0]  sel[4] = '{WB_SEL_ALU, WB_SEL_PC4, 2'd3, WB_SEL_ALU};
    logic        rw[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exd[4] = '{32'hA5A50001, 32'h00001008, 32'hA5A50001, 32'hA5A50001};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 5'd7, rw[i], sel[i], LD_LW, 2'd0, 32'hA5A50001, 32'hFFFFFFFF, 32'h00001008);
      if (rw[i]) expect_wr(5'd7, exd[i]);
      exp_instret++;
      tick;
      in_valid = 1'b0; #1;
      checks++;
      if (rf_we !== rw[i] || rf_wd !== exd[i]) begin
        errors++;
        $display("FAIL wb_sel_%0d got we=%b wd=%h want we=%b wd=%h", i, rf_we, rf_wd, rw[i], exd[i]);
      end
      tick;
    end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL wb_sel_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_x0;
    set_in(1'b1, 5'd0, 1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h5, 32'h0, 32'h0);
    exp_instret++;
    tick;
    in_valid = 1'b0; #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_rf_we got %b want 0", rf_we); end
    tick;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL x0_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_hold;
    do_reset;
    set_in(1'b1, 5'd1, 1'b1, WB_SEL_PC4, LD_LW, 2'd0, 32'h0, 32'h0, 32'h104);
    expect_wr(5'd1, 32'h104);
    tick;
    in_valid = 1'b0; wb_hold = 1'b1; #1;
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (rf_we !== 1'b0 || in_ready !== 1'b0 || instret !== 32'd0) begin
        errors++;
        $display("FAIL hold_cycle_%0d got we=%b rdy=%b instret=%0d want 0 0 0", h, rf_we, in_ready, instret);
      end
      tick;
    end
    wb_hold = 1'b0; #1;
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd1 || rf_wd !== 32'h104) begin
      errors++;
      $display("FAIL hold_release got we=%b wa=%0d wd=%h want 1 1 104", rf_we, rf_wa, rf_wd);
    end
    exp_instret++;
    tick;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_single_write got we=%b want 0", rf_we); end
    checks++; if (rf_model[1] !== 32'h104) begin errors++; $display("FAIL hold_x1 got %h want 104", rf_model[1]); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL hold_instret got %0d want 1", instret); end
    checks++; if (q_rd.size() != 0) begin errors++; $display("FAIL hold_pending got %0d want 0", q_rd.size()); end
  endtask

  task automatic test_flush;
    set_in(1'b1, 5'd2, 1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'hAA, 32'h0, 32'h0);
    tick;
    in_valid = 1'b0; flush = 1'b1; #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", rf_we); end
    tick;
    flush = 1'b0; #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_after_we got %b want 0", rf_we); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL flush_instret got %0d want %0d", instret, exp_instret); end
    set_in(1'b1, 5'd3, 1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'hBB, 32'h0, 32'h0);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_drop_we got %b want 0", rf_we); end
    tick;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL flush_drop_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 5'(i), 1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h1000 + 32'(i), 32'h0, 32'h0);
      if (i != 5) begin
        expect_wr(5'(i), 32'h1000 + 32'(i));
        exp_instret++;
      end
      tick;
      if (i == 5) begin
        #1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL b2b_pre_reset_instret got %0d want %0d", instret, exp_instret); end
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL b2b_pending_we got %b want 1", rf_we); end
        rst_n = 1'b0; in_valid = 1'b0; #1;
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0 || instret !== 32'd0) begin
          errors++;
          $display("FAIL b2b_async_reset got we=%b wa=%0d wd=%h instret=%0d want all 0", rf_we, rf_wa, rf_wd, instret);
        end
        tick;
        rst_n = 1'b1;
        exp_instret = '0;
      end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL b2b_instret got %0d want %0d", instret, exp_instret); end
    checks++; if (q_rd.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d want 0", q_rd.size()); end
    for (int k = 1; k <= 10; k++) begin
      if (k != 5) begin
        checks++;
        if (rf_model[k] !== 32'h1000 + 32'(k)) begin
          errors++;
          $display("FAIL b2b_x%0d got %h want %h", k, rf_model[k], 32'h1000 + 32'(k));
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    test_reset;
    test_loads;
    test_wb_sel;
    test_x0;
    test_hold;
    test_flush;
    test_back_to_back;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
